accelerator_write_heads_controller: RTL and testbench
=====================================================

ACCELERATOR_WRITE_HEADS_CONTROLLER -- requirements
Module: accelerator_write_heads_controller

Interface
REQ-001 Parameter DATA_SIZE, default 64, width of the size, index and data-path words.
REQ-002 Parameter TIMEOUT_CYCLES, default 256, response watchdog limit, used only under REQ-030.
REQ-003 CLK  in  1  single clock; all state changes on its rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 START  in  1  one-cycle request to run one write-heads update.
REQ-006 READY  out  1  high when idle and able to accept START.
REQ-007 DONE  out  1  one-cycle pulse when a run ends.
REQ-008 ERROR  out  1  one-cycle pulse, coincident with DONE, on an aborted or rejected run.
REQ-009 SIZE_N_IN, SIZE_W_IN  in  DATA_SIZE  memory rows N and row width W.
REQ-010 INDEX_J, INDEX_K  out  DATA_SIZE  current row and column, used to address source buffers.
REQ-011 HEAD_START  out  1  one-cycle start pulse to the write-heads datapath.
REQ-012 HEAD_A_IN_ENABLE, HEAD_W_IN_ENABLE, HEAD_M_IN_J_ENABLE, HEAD_M_IN_K_ENABLE  out  1  element-valid strobes to the datapath.
REQ-013 HEAD_M_OUT_K_ENABLE  in  1  datapath has produced the M element for (INDEX_J, INDEX_K).
REQ-014 HEAD_READY  in  1  datapath has finished the full update.

Function
REQ-015 States: IDLE, A_LOAD, W_LOAD, M_ISSUE, M_WAIT, NEXT_J, FINISH; encoding is free.
REQ-016 IDLE: READY=1. START=1 latches SIZE_N_IN/SIZE_W_IN, drops READY next cycle and pulses HEAD_START that cycle.
REQ-017 If either latched size is 0, the controller issues no strobes, pulses DONE and ERROR one cycle after START, and remains in IDLE with READY=1.
REQ-018 A_LOAD: HEAD_A_IN_ENABLE=1 for exactly W consecutive cycles, with INDEX_K=0..W-1 and INDEX_J=0; then W_LOAD.
REQ-019 W_LOAD: HEAD_W_IN_ENABLE=1 and HEAD_M_IN_J_ENABLE=1 for one cycle at the current INDEX_J; INDEX_K resets to 0; then M_ISSUE.
REQ-020 M_ISSUE: HEAD_M_IN_K_ENABLE=1 for one cycle; then M_WAIT.
REQ-021 M_WAIT: all strobes are 0 until HEAD_M_OUT_K_ENABLE=1. If INDEX_K<W-1, INDEX_K increments and the next state is M_ISSUE; otherwise the next state is NEXT_J.
REQ-022 NEXT_J: if INDEX_J<N-1, INDEX_J increments and the next state is W_LOAD; otherwise FINISH.
REQ-023 FINISH: waits for HEAD_READY=1, then pulses DONE (ERROR=0) and returns to IDLE; READY=1 the following cycle.
REQ-024 HEAD_M_OUT_K_ENABLE outside M_WAIT and HEAD_READY outside FINISH are ignored.
REQ-025 START while READY=0 is ignored; latched sizes do not change mid-run.
REQ-026 Index counters are DATA_SIZE wide compared against size-1; no wrap occurs because sizes are at least 1 after REQ-017.
REQ-027 Per run, exactly W A strobes, N W strobes, N M_IN_J strobes and N*W M_IN_K strobes are issued.

Reset
REQ-028 RST=1 at any edge, including mid-run, forces IDLE; READY=1; DONE, ERROR, HEAD_START and all strobes =0; INDEX_J=INDEX_K=0; latched sizes =0.
REQ-029 A run interrupted by reset produces no DONE; START is accepted in the first cycle after RST deasserts.

Configuration
REQ-030 Macro ACCELERATOR_WRITE_HEADS_TIMEOUT_EN defined: a counter clears on entry to M_WAIT or FINISH. If it reaches TIMEOUT_CYCLES without the awaited input, DONE and ERROR pulse and the state returns to IDLE.
REQ-031 Macro undefined: no watchdog logic is present; M_WAIT and FINISH wait indefinitely.

Verification
REQ-032 N=2, W=3, datapath answers 1 cycle after each M_IN_K and HEAD_READY immediately -> 3 A strobes (k=0,1,2), 2 W strobes, 6 M_IN_K strobes in (j,k) order (0,0)..(1,2), one DONE, ERROR=0.
REQ-033 START with N=0, W=4 -> no strobes; DONE=ERROR=1 for one cycle, one cycle after START; READY stays 1.
REQ-034 START pulsed again during M_WAIT with N=5 -> ignored; run completes with the original sizes and strobe counts.
REQ-035 RST asserted during M_WAIT at j=1, k=2 -> next cycle is IDLE with all outputs at reset values and no DONE; a new START with N=1, W=1 completes normally.
REQ-036 With TIMEOUT_EN and TIMEOUT_CYCLES=8, HEAD_M_OUT_K_ENABLE held 0 -> DONE=ERROR=1 after 8 cycles in M_WAIT, then READY=1. Without the macro, there is no DONE after 1000 cycles.

Source files
------------

// File: rtl/accelerator_write_heads_controller.sv
// Write-heads sequencer: streams A, W and M element strobes over an N x W memory and hands off to the datapath.
// Optional response watchdog enabled by defining ACCELERATOR_WRITE_HEADS_TIMEOUT_EN.
module accelerator_write_heads_controller #(
  parameter int DATA_SIZE      = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  output logic                 DONE,
  output logic                 ERROR,
  input  logic [DATA_SIZE-1:0] SIZE_N_IN,
  input  logic [DATA_SIZE-1:0] SIZE_W_IN,
  output logic [DATA_SIZE-1:0] INDEX_J,
  output logic [DATA_SIZE-1:0] INDEX_K,
  output logic                 HEAD_START,
  output logic                 HEAD_A_IN_ENABLE,
  output logic                 HEAD_W_IN_ENABLE,
  output logic                 HEAD_M_IN_J_ENABLE,
  output logic                 HEAD_M_IN_K_ENABLE,
  input  logic                 HEAD_M_OUT_K_ENABLE,
  input  logic                 HEAD_READY
);

  typedef enum logic [2:0] {IDLE, A_LOAD, W_LOAD, M_ISSUE, M_WAIT, NEXT_J, FINISH} state_t;

  localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1);

  if (TIMEOUT_CYCLES < 1) begin : g_tmo_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t               state;
  logic [DATA_SIZE-1:0] size_n, size_w;

`ifdef ACCELERATOR_WRITE_HEADS_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  logic [WDW-1:0] wd_cnt;
`endif

  // Outputs are registered: each strobe is set on the edge that enters the state it belongs to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state              <= IDLE;
      READY              <= 1'b1;
      DONE               <= 1'b0;
      ERROR              <= 1'b0;
      HEAD_START         <= 1'b0;
      HEAD_A_IN_ENABLE   <= 1'b0;
      HEAD_W_IN_ENABLE   <= 1'b0;
      HEAD_M_IN_J_ENABLE <= 1'b0;
      HEAD_M_IN_K_ENABLE <= 1'b0;
      INDEX_J            <= '0;
      INDEX_K            <= '0;
      size_n             <= '0;
      size_w             <= '0;
`ifdef ACCELERATOR_WRITE_HEADS_TIMEOUT_EN
      wd_cnt             <= '0;
`endif
    end else begin
      DONE               <= 1'b0;
      ERROR              <= 1'b0;
      HEAD_START         <= 1'b0;
      HEAD_A_IN_ENABLE   <= 1'b0;
      HEAD_W_IN_ENABLE   <= 1'b0;
      HEAD_M_IN_J_ENABLE <= 1'b0;
      HEAD_M_IN_K_ENABLE <= 1'b0;
      case (state)
        IDLE: if (START) begin
          size_n  <= SIZE_N_IN;
          size_w  <= SIZE_W_IN;
          INDEX_J <= '0;
          INDEX_K <= '0;
          // Empty geometry is rejected without leaving IDLE.
          if (SIZE_N_IN == '0 || SIZE_W_IN == '0) begin
            DONE  <= 1'b1;
            ERROR <= 1'b1;
          end else begin
            state            <= A_LOAD;
            READY            <= 1'b0;
            HEAD_START       <= 1'b1;
            HEAD_A_IN_ENABLE <= 1'b1;
          end
        end
        A_LOAD: if (INDEX_K < size_w - ONE) begin
          INDEX_K          <= INDEX_K + ONE;
          HEAD_A_IN_ENABLE <= 1'b1;
        end else begin
          state              <= W_LOAD;
          INDEX_K            <= '0;
          HEAD_W_IN_ENABLE   <= 1'b1;
          HEAD_M_IN_J_ENABLE <= 1'b1;
        end
        W_LOAD: begin
          state              <= M_ISSUE;
          HEAD_M_IN_K_ENABLE <= 1'b1;
        end
        M_ISSUE: begin
          state <= M_WAIT;
`ifdef ACCELERATOR_WRITE_HEADS_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        M_WAIT: if (HEAD_M_OUT_K_ENABLE) begin
          if (INDEX_K < size_w - ONE) begin
            INDEX_K            <= INDEX_K + ONE;
            state              <= M_ISSUE;
            HEAD_M_IN_K_ENABLE <= 1'b1;
          end else begin
            state <= NEXT_J;
          end
        end
`ifdef ACCELERATOR_WRITE_HEADS_TIMEOUT_EN
        else if (wd_cnt == WD_LAST) begin
          state <= IDLE;
          READY <= 1'b1;
          DONE  <= 1'b1;
          ERROR <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
`endif
        NEXT_J: if (INDEX_J < size_n - ONE) begin
          INDEX_J            <= INDEX_J + ONE;
          INDEX_K            <= '0;
          state              <= W_LOAD;
          HEAD_W_IN_ENABLE   <= 1'b1;
          HEAD_M_IN_J_ENABLE <= 1'b1;
        end else begin
          state <= FINISH;
`ifdef ACCELERATOR_WRITE_HEADS_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        FINISH: if (HEAD_READY) begin
          state <= IDLE;
          READY <= 1'b1;
          DONE  <= 1'b1;
        end
`ifdef ACCELERATOR_WRITE_HEADS_TIMEOUT_EN
        else if (wd_cnt == WD_LAST) begin
          state <= IDLE;
          READY <= 1'b1;
          DONE  <= 1'b1;
          ERROR <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
`endif
        default: begin
          state <= IDLE;
          READY <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accelerator_write_heads_controller.sv
// Bench for accelerator_write_heads_controller: an ordered strobe-token model checked every cycle plus directed literal checks.
module tb_accelerator_write_heads_controller;
  localparam int DW = 64;

  logic          CLK = 1'b0, RST = 1'b1, START = 1'b0;
  logic          HEAD_M_OUT_K_ENABLE = 1'b0, HEAD_READY = 1'b1;
  logic [DW-1:0] SIZE_N_IN = '0, SIZE_W_IN = '0;
  logic          READY, DONE, ERROR, HEAD_START;
  logic          HEAD_A_IN_ENABLE, HEAD_W_IN_ENABLE, HEAD_M_IN_J_ENABLE, HEAD_M_IN_K_ENABLE;
  logic [DW-1:0] INDEX_J, INDEX_K;

  always #5 CLK = ~CLK;

  accelerator_write_heads_controller #(.DATA_SIZE(DW), .TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY), .DONE(DONE), .ERROR(ERROR),
    .SIZE_N_IN(SIZE_N_IN), .SIZE_W_IN(SIZE_W_IN), .INDEX_J(INDEX_J), .INDEX_K(INDEX_K),
    .HEAD_START(HEAD_START), .HEAD_A_IN_ENABLE(HEAD_A_IN_ENABLE), .HEAD_W_IN_ENABLE(HEAD_W_IN_ENABLE),
    .HEAD_M_IN_J_ENABLE(HEAD_M_IN_J_ENABLE), .HEAD_M_IN_K_ENABLE(HEAD_M_IN_K_ENABLE),
    .HEAD_M_OUT_K_ENABLE(HEAD_M_OUT_K_ENABLE), .HEAD_READY(HEAD_READY)
  );

  // kind: 0 = A element, 1 = W row (with M_IN_J), 2 = M_IN_K element
  typedef struct {int kind; int j; int k;} tok_t;
  tok_t exp_q[$];

  int n_pass = 0, n_total = 0;
  int cnt_a, cnt_w, cnt_mj, cnt_mk, cnt_done, cnt_err, cnt_hs;
  bit busy = 0, exp_done = 0, exp_err = 0, exp_hs = 0, chk_rst = 0;
  bit resp_en = 1, kick = 0, mk_prev = 0;

  task automatic check(string name, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Datapath stand-in: holds M_OUT_K for two cycles per M_IN_K so the answer lands in M_WAIT.
  initial forever begin
    @(posedge CLK); #2;
    HEAD_M_OUT_K_ENABLE = kick || (resp_en && (HEAD_M_IN_K_ENABLE || mk_prev));
    mk_prev = HEAD_M_IN_K_ENABLE;
  end

  // Model: an accepted run expects its strobes as an ordered token list; DONE is legal once the list drains.
  always @(negedge CLK) begin
    tok_t tok;
    int   ns, kind;
    if (DONE) begin cnt_done++; if (ERROR) cnt_err++; end
    if (DONE && !exp_done) begin
      if (busy && exp_q.size() == 0) begin
        busy = 0;
        check("run_error", ERROR, 0);
      end
`ifdef ACCELERATOR_WRITE_HEADS_TIMEOUT_EN
      else if (busy) begin
        busy = 0;
        exp_q.delete();
        check("timeout_error", ERROR, 1);
      end
`endif
      else check("spurious_done", DONE, 0);
    end else begin
      check("done", DONE, exp_done);
      check("error", ERROR, exp_done && exp_err);
    end
    check("ready", READY, !busy);
    check("head_start", HEAD_START, exp_hs);
    check("mj_with_w", HEAD_M_IN_J_ENABLE, HEAD_W_IN_ENABLE);
    if (HEAD_START) cnt_hs++;
    if (HEAD_A_IN_ENABLE) cnt_a++;
    if (HEAD_W_IN_ENABLE) cnt_w++;
    if (HEAD_M_IN_J_ENABLE) cnt_mj++;
    if (HEAD_M_IN_K_ENABLE) cnt_mk++;
    ns = int'(HEAD_A_IN_ENABLE) + int'(HEAD_W_IN_ENABLE) + int'(HEAD_M_IN_K_ENABLE);
    if (ns > 0) begin
      check("one_strobe", ns, 1);
      if (exp_q.size() == 0) check("unexpected_strobe", ns, 0);
      else begin
        tok  = exp_q.pop_front();
        kind = HEAD_A_IN_ENABLE ? 0 : (HEAD_W_IN_ENABLE ? 1 : 2);
        check("strobe_kind", kind, tok.kind);
        check("strobe_j", INDEX_J, tok.j);
        check("strobe_k", INDEX_K, tok.k);
      end
    end
    if (chk_rst) begin
      check("rst_index_j", INDEX_J, 0);
      check("rst_index_k", INDEX_K, 0);
    end
    exp_done = 0; exp_err = 0; exp_hs = 0; chk_rst = 0;
    if (RST) begin
      busy = 0;
      exp_q.delete();
      chk_rst = 1;
    end else if (START && !busy) begin
      if (SIZE_N_IN == 0 || SIZE_W_IN == 0) begin
        exp_done = 1; exp_err = 1;
      end else begin
        busy = 1; exp_hs = 1;
        for (int k = 0; k < int'(SIZE_W_IN); k++) exp_q.push_back('{0, 0, k});
        for (int j = 0; j < int'(SIZE_N_IN); j++) begin
          exp_q.push_back('{1, j, 0});
          for (int k = 0; k < int'(SIZE_W_IN); k++) exp_q.push_back('{2, j, k});
        end
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic clr_counts();
    cnt_a = 0; cnt_w = 0; cnt_mj = 0; cnt_mk = 0; cnt_done = 0; cnt_err = 0; cnt_hs = 0;
  endtask

  task automatic start_run(int n, int w);
    SIZE_N_IN = DW'(n); SIZE_W_IN = DW'(w); START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic wait_done(int bound);
    int c = 0;
    while (!DONE && c < bound) begin step(); c++; end
    check("done_seen", DONE, 1);
  endtask

  task automatic expect_counts(string tag, int a, int w, int mk, int done_n, int err_n);
    check({tag, "_a"}, cnt_a, a);
    check({tag, "_w"}, cnt_w, w);
    check({tag, "_mj"}, cnt_mj, w);
    check({tag, "_mk"}, cnt_mk, mk);
    check({tag, "_done"}, cnt_done, done_n);
    check({tag, "_err"}, cnt_err, err_n);
  endtask

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int c;
    int tbl_n[3] = '{3, 1, 2};
    int tbl_w[3] = '{1, 4, 2};
    clr_counts();
    step(2);
    // reset state
    check("rst_ready", READY, 1);
    check("rst_done", DONE, 0);
    check("rst_error", ERROR, 0);
    check("rst_strobes", {HEAD_START, HEAD_A_IN_ENABLE, HEAD_W_IN_ENABLE, HEAD_M_IN_J_ENABLE, HEAD_M_IN_K_ENABLE}, 0);
    check("rst_j", INDEX_J, 0);
    RST = 1'b0;
    step();

    // N=2, W=3 nominal run
    clr_counts();
    start_run(2, 3);
    check("run1_ready_low", READY, 0);
    check("run1_head_start", HEAD_START, 1);
    check("run1_first_a", HEAD_A_IN_ENABLE, 1);
    check("run1_first_k", INDEX_K, 0);
    wait_done(100);
    check("run1_done_err", ERROR, 0);
    check("run1_done_ready", READY, 1);
    step();
    check("run1_done_pulse", DONE, 0);
    expect_counts("run1", 3, 2, 6, 1, 0);
    check("run1_hs", cnt_hs, 1);

    // zero-size rejection
    clr_counts();
    start_run(0, 4);
    check("zero_done", DONE, 1);
    check("zero_error", ERROR, 1);
    check("zero_ready", READY, 1);
    check("zero_hs", HEAD_START, 0);
    step();
    check("zero_done_pulse", DONE, 0);
    start_run(3, 0);
    check("zero_w_done", {DONE, ERROR}, 3);
    step(2);
    expect_counts("zero", 0, 0, 0, 2, 2);

    // assorted geometries
    for (int i = 0; i < 3; i++) begin
      clr_counts();
      start_run(tbl_n[i], tbl_w[i]);
      wait_done(200);
      step();
      expect_counts("geom", tbl_w[i], tbl_n[i], tbl_n[i] * tbl_w[i], 1, 0);
    end

    // START during M_WAIT is ignored
    clr_counts();
    resp_en = 0;
    start_run(2, 2);
    c = 0;
    while (!HEAD_M_IN_K_ENABLE && c < 20) begin step(); c++; end
    check("busy_mk_seen", HEAD_M_IN_K_ENABLE, 1);
    step(3);
    SIZE_N_IN = DW'(5); START = 1'b1;
    step();
    START = 1'b0;
    check("busy_start_ignored", READY, 0);
    kick = 1;
    step();
    kick = 0; resp_en = 1;
    wait_done(200);
    step();
    expect_counts("busy", 2, 2, 4, 1, 0);

    // reset in M_WAIT at j=1, k=2
    clr_counts();
    start_run(2, 3);
    c = 0;
    while (!(HEAD_M_IN_K_ENABLE && INDEX_J == 1 && INDEX_K == 2) && c < 100) begin step(); c++; end
    check("mid_found", HEAD_M_IN_K_ENABLE, 1);
    resp_en = 0;
    step();
    check("mid_wait_idle_strobes", {HEAD_A_IN_ENABLE, HEAD_W_IN_ENABLE, HEAD_M_IN_K_ENABLE}, 0);
    check("mid_wait_j", INDEX_J, 1);
    check("mid_wait_k", INDEX_K, 2);
    RST = 1'b1;
    step();
    check("mid_rst_ready", READY, 1);
    check("mid_rst_outs", {DONE, ERROR, HEAD_START, HEAD_A_IN_ENABLE, HEAD_W_IN_ENABLE, HEAD_M_IN_J_ENABLE, HEAD_M_IN_K_ENABLE}, 0);
    check("mid_rst_jk", INDEX_J | INDEX_K, 0);
    RST = 1'b0; resp_en = 1;
    clr_counts();
    start_run(1, 1);
    check("post_rst_accept", READY, 0);
    wait_done(50);
    step();
    expect_counts("post_rst", 1, 1, 1, 1, 0);

    // datapath never answers
    clr_counts();
    resp_en = 0;
    start_run(1, 1);
    c = 0;
    while (!HEAD_M_IN_K_ENABLE && c < 20) begin step(); c++; end
    check("hang_mk_seen", HEAD_M_IN_K_ENABLE, 1);
`ifdef ACCELERATOR_WRITE_HEADS_TIMEOUT_EN
    c = 0;
    while (!DONE && c < 30) begin step(); c++; end
    check("tmo_latency", c, 9);
    check("tmo_flags", {DONE, ERROR}, 3);
    step();
    check("tmo_ready", READY, 1);
`else
    step(1000);
    check("hang_no_done", cnt_done, 0);
    check("hang_ready", READY, 0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("hang_rst_ready", READY, 1);
`endif
    resp_en = 1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
